brnch_pred_nbit_dyn: RTL and testbench
======================================

# brnch_pred_nbit_dyn

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline, and the successor to the 1-bit local-history predictor. It holds a 2^IDX_W-entry table of CNT_W-bit saturating counters and supports two indexing modes: bimodal (PC-indexed) or gshare (PC XOR global history). It predicts in IF, resolves in ID against the branch comparator result, updates the table, and generates the mispredict flush. Saturating performance counters for branches and mispredicts are included.

## Interface
- IDX_W, 5, table index width; table depth = 2^IDX_W.
- CNT_W, 2, counter width, 1..4; CNT_W=1 reproduces the 1-bit predictor.
- MODE, 0, 0 = bimodal, 1 = gshare.
- GHR_W, 5, global history width, 1..IDX_W; ignored when MODE=0.
- STAT_W, 16, performance counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- brch_instr_detectd_IF  in  1  beq decoded in IF.
- branch_addr_IF  in  IDX_W  low PC word-address bits of the IF instruction.
- brch_instr_detectd_ID  in  1  beq present in ID.
- brch_hazard_stall  in  1  ID branch operand hazard; freezes IF/ID.
- actual_brch_result  in  1  resolved outcome in ID (1 = taken); valid only when brch_instr_detectd_ID=1.
- prediction  out  1  taken prediction for the IF instruction.
- flush  out  1  mispredict; squash IF and redirect the PC.
- perf_brnch_cnt  out  STAT_W  resolved branches.
- perf_mispred_cnt  out  STAT_W  mispredicts.

## Operation
- Table: 2^IDX_W counters. Reset value = 2^(CNT_W-1)-1, i.e. weakly not-taken. For CNT_W=1 the reset value is 0.
- Lookup index idx_IF:
  - MODE=0: branch_addr_IF.
  - MODE=1: branch_addr_IF XOR zero-extended GHR.
- prediction = brch_instr_detectd_IF & !brch_hazard_stall & MSB(table[idx_IF]).
- ID pipeline state (pred_ID, idx_ID):
  - If !brch_hazard_stall: pred_ID <= prediction and idx_ID <= idx_IF.
  - Otherwise both hold.
- Resolve event: res = brch_instr_detectd_ID & !brch_hazard_stall.
- On res, table[idx_ID] is updated:
  - Taken: increment, saturating at 2^CNT_W-1.
  - Not-taken: decrement, saturating at 0.
- On res with MODE=1: GHR <= {GHR[GHR_W-2:0], actual_brch_result}. The GHR is non-speculative. For GHR_W=1 the GHR is simply the last outcome.
- flush = res & (actual_brch_result != pred_ID). The flush is gated by branch detect, so a non-branch in ID never flushes.
- Perf counters on res:
  - perf_brnch_cnt increments.
  - perf_mispred_cnt increments if flush.
  - Both saturate at all-ones and do not wrap.
- Reset clears pred_ID, idx_ID, GHR and both perf counters to 0, and sets table entries to their reset value.

## Timing
- prediction is combinational from table/GHR registers in the same cycle as the IF inputs.
- flush is combinational in the resolve cycle.
- The table and GHR update takes effect on the next rising edge.
- Simultaneous lookup and update of the same index: the lookup sees the pre-update value. There is no bypass.
- In gshare mode, a lookup in the resolve cycle uses the pre-shift GHR.
- Stall: while brch_hazard_stall=1, prediction=0, flush=0, and there is no table, GHR or perf update. pred_ID and idx_ID hold. The resolve happens in the first unstalled cycle.
- After a flush, the squashed IF slot enters ID as a bubble (brch_instr_detectd_ID=0). Its stale pred_ID is never compared.
- Reset asserted mid-operation returns everything to reset values on that edge. Outputs in the reset cycle:
  - prediction follows the reset-value table, so it is 0 when CNT_W>1.
  - flush depends only on current inputs and pred_ID, so it is 0 only if the inputs are held idle.

## Test plan
- Reset: rst_n=0 for 1 cycle, then IF branch at addr 3 (CNT_W=2) -> prediction=0, perf counters=0, flush=0 with idle inputs.
- Bimodal training (MODE=0, CNT_W=2):
  - addr 3 resolves taken: first resolve flush=1, counter 01->10, next lookup prediction=1.
  - Two further taken resolves: counter saturates at 11.
  - One not-taken resolve: counter 10, still predicts 1.
- Stall hold: brch_hazard_stall=1 for 3 cycles with a branch in ID -> flush=0, prediction=0, no update. After release: a single resolve, perf_brnch_cnt +1.
- Gshare (MODE=1, GHR_W=2):
  - After outcomes T,N, GHR=2'b10.
  - Branch at addr 5 indexes entry 7.
  - Training entry 7 does not change the prediction for addr 5 in bimodal mode.
- Same-cycle hazard: resolve idx 4 taken while looking up addr 4 -> prediction uses the old value; the next-cycle lookup sees the new value.
- Saturation: STAT_W=4, 20 resolves, all mispredicted -> perf_brnch_cnt and perf_mispred_cnt hold at 15. Reset mid-stream -> both read 0 on the next cycle.

Source files
------------

// File: rtl/brnch_pred_nbit_dyn.sv
// rtl/brnch_pred_nbit_dyn.sv - n-bit saturating-counter branch predictor, bimodal or gshare indexed
module brnch_pred_nbit_dyn #(
    parameter int IDX_W  = 5,
    parameter int CNT_W  = 2,
    parameter int MODE   = 0,
    parameter int GHR_W  = 5,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              brch_instr_detectd_IF,
    input  logic [IDX_W-1:0]  branch_addr_IF,
    input  logic              brch_instr_detectd_ID,
    input  logic              brch_hazard_stall,
    input  logic              actual_brch_result,
    output logic              prediction,
    output logic              flush,
    output logic [STAT_W-1:0] perf_brnch_cnt,
    output logic [STAT_W-1:0] perf_mispred_cnt
);

    localparam int               DEPTH   = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_tbl [DEPTH];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_nxt;
    logic [IDX_W-1:0] ghr_ext;
    logic [IDX_W-1:0] idx_if;
    logic [IDX_W-1:0] idx_id;
    logic [CNT_W-1:0] cnt_id;
    logic             pred_id;
    logic             res;

    always_comb begin
        ghr_ext              = '0;
        ghr_ext[GHR_W-1:0]   = ghr_q;
    end

    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign ghr_nxt = actual_brch_result;
        end else begin : g_ghr_shift
            assign ghr_nxt = {ghr_q[GHR_W-2:0], actual_brch_result};
        end
    endgenerate

    assign idx_if     = (MODE == 1) ? (branch_addr_IF ^ ghr_ext) : branch_addr_IF;
    assign prediction = brch_instr_detectd_IF & ~brch_hazard_stall & cnt_tbl[idx_if][CNT_W-1];
    assign res        = brch_instr_detectd_ID & ~brch_hazard_stall;
    assign flush      = res & (actual_brch_result != pred_id);
    assign cnt_id     = cnt_tbl[idx_id];

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_tbl[i] <= CNT_RST;
            end
        end else if (res) begin
            if (actual_brch_result) begin
                if (cnt_id != CNT_MAX) begin
                    cnt_tbl[idx_id] <= cnt_id + 1'b1;
                end
            end else if (cnt_id != '0) begin
                cnt_tbl[idx_id] <= cnt_id - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_id          <= 1'b0;
            idx_id           <= '0;
            ghr_q            <= '0;
            perf_brnch_cnt   <= '0;
            perf_mispred_cnt <= '0;
        end else begin
            if (!brch_hazard_stall) begin
                pred_id <= prediction;
                idx_id  <= idx_if;
            end
            if (res) begin
                // History holds only resolved outcomes, never speculative ones.
                if (MODE == 1) begin
                    ghr_q <= ghr_nxt;
                end
                if (perf_brnch_cnt != '1) begin
                    perf_brnch_cnt <= perf_brnch_cnt + 1'b1;
                end
                if (flush && (perf_mispred_cnt != '1)) begin
                    perf_mispred_cnt <= perf_mispred_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_brnch_pred_nbit_dyn.sv
// tb/tb_brnch_pred_nbit_dyn.sv - three predictor configurations checked against a behavioural model
module tb_brnch_pred_nbit_dyn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, det_if, det_id, stall, act;
    logic [4:0] addr;
    logic [2:0] pred_v, flush_v;
    logic [15:0] pb0, pm0, pb1, pm1;
    logic [3:0]  pb2, pm2;

    int checks = 0;
    int errors = 0;

    brnch_pred_nbit_dyn #(.IDX_W(5), .CNT_W(2), .MODE(0), .GHR_W(5), .STAT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .brch_instr_detectd_IF(det_if), .branch_addr_IF(addr),
        .brch_instr_detectd_ID(det_id), .brch_hazard_stall(stall), .actual_brch_result(act),
        .prediction(pred_v[0]), .flush(flush_v[0]), .perf_brnch_cnt(pb0), .perf_mispred_cnt(pm0));

    brnch_pred_nbit_dyn #(.IDX_W(5), .CNT_W(2), .MODE(1), .GHR_W(2), .STAT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .brch_instr_detectd_IF(det_if), .branch_addr_IF(addr),
        .brch_instr_detectd_ID(det_id), .brch_hazard_stall(stall), .actual_brch_result(act),
        .prediction(pred_v[1]), .flush(flush_v[1]), .perf_brnch_cnt(pb1), .perf_mispred_cnt(pm1));

    brnch_pred_nbit_dyn #(.IDX_W(5), .CNT_W(3), .MODE(1), .GHR_W(5), .STAT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .brch_instr_detectd_IF(det_if), .branch_addr_IF(addr),
        .brch_instr_detectd_ID(det_id), .brch_hazard_stall(stall), .actual_brch_result(act),
        .prediction(pred_v[2]), .flush(flush_v[2]), .perf_brnch_cnt(pb2), .perf_mispred_cnt(pm2));

    // Reference model: per-instance counters as plain integers, history as an integer.
    int c_mode [3] = '{0, 1, 1};
    int c_ghrw [3] = '{5, 2, 5};
    int c_cntw [3] = '{2, 2, 3};
    int c_smax [3] = '{65535, 65535, 15};
    int cnt [3][32];
    int ghr [3];
    int pid [3];
    int iid [3];
    int nb [3];
    int nm [3];
    int exp_pred [3];
    int exp_flush [3];
    int exp_idx [3];

    function automatic int look(int k, int a);
        return (c_mode[k] == 1) ? (a ^ ghr[k]) : a;
    endfunction

    function automatic int taken_of(int k, int a);
        return (cnt[k][look(k, a)] >= (1 << (c_cntw[k] - 1))) ? 1 : 0;
    endfunction

    function automatic logic [2:0] vec_pred();
        return {exp_pred[2] != 0, exp_pred[1] != 0, exp_pred[0] != 0};
    endfunction

    function automatic logic [2:0] vec_flush();
        return {exp_flush[2] != 0, exp_flush[1] != 0, exp_flush[0] != 0};
    endfunction

    function automatic logic [71:0] exp_perf();
        return {16'(nb[0]), 16'(nm[0]), 16'(nb[1]), 16'(nm[1]), 4'(nb[2]), 4'(nm[2])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) cnt[k][i] = (1 << (c_cntw[k] - 1)) - 1;
            ghr[k] = 0; pid[k] = 0; iid[k] = 0; nb[k] = 0; nm[k] = 0;
        end
    endtask

    task automatic model_eval();
        for (int k = 0; k < 3; k++) begin
            exp_idx[k]   = look(k, int'(addr));
            exp_pred[k]  = (det_if && !stall) ? taken_of(k, int'(addr)) : 0;
            exp_flush[k] = (det_id && !stall && (int'(act) != pid[k])) ? 1 : 0;
        end
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (det_id && !stall) begin
                    if (act) cnt[k][iid[k]] = (cnt[k][iid[k]] + 1 > (1 << c_cntw[k]) - 1) ? cnt[k][iid[k]] : cnt[k][iid[k]] + 1;
                    else     cnt[k][iid[k]] = (cnt[k][iid[k]] == 0) ? 0 : cnt[k][iid[k]] - 1;
                    if (c_mode[k] == 1) ghr[k] = ((ghr[k] << 1) | int'(act)) % (1 << c_ghrw[k]);
                    if (nb[k] < c_smax[k]) nb[k]++;
                    if (exp_flush[k] != 0 && nm[k] < c_smax[k]) nm[k]++;
                end
                if (!stall) begin
                    pid[k] = exp_pred[k];
                    iid[k] = exp_idx[k];
                end
            end
        end
    endtask

    task automatic set_in(input bit di, input int a, input bit dd, input bit st, input bit ac);
        det_if = di; addr = 5'(a); det_id = dd; stall = st; act = ac;
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0; set_in(0, 0, 0, 0, 0); settle(); tick();
        rst_n = 1'b1;
    endtask

    task automatic branch_pair(input int a, input bit ac, output logic [2:0] p, output logic [2:0] f,
                               output logic [2:0] ep, output logic [2:0] ef);
        set_in(1, a, 0, 0, 0); settle(); p = pred_v; ep = vec_pred(); tick();
        set_in(0, 0, 1, 0, ac); settle(); f = flush_v; ef = vec_flush(); tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_in(0, 0, 0, 0, 0); settle();
        checks++; if (flush_v !== 3'b000) begin errors++; $display("FAIL reset_cycle_flush got=%b exp=000", flush_v); end
        tick();
        rst_n = 1'b1; set_in(1, 3, 0, 0, 0); settle();
        checks++; if (pred_v !== 3'b000) begin errors++; $display("FAIL reset_pred got=%b exp=000", pred_v); end
        checks++; if (flush_v !== 3'b000) begin errors++; $display("FAIL reset_flush got=%b exp=000", flush_v); end
        checks++; if ({pb0, pm0, pb1, pm1, pb2, pm2} !== 72'd0) begin errors++; $display("FAIL reset_perf got=%h exp=0", {pb0, pm0, pb1, pm1, pb2, pm2}); end
        tick();
    endtask

    task automatic test_bimodal_training();
        logic [2:0] p, f, ep, ef;
        bit acts [4] = '{1, 1, 1, 0};
        bit want_p [4] = '{0, 1, 1, 1};
        bit want_f [4] = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            branch_pair(3, acts[i], p, f, ep, ef);
            checks++; if (p[0] !== want_p[i]) begin errors++; $display("FAIL bim_pred[%0d] got=%b exp=%b", i, p[0], want_p[i]); end
            checks++; if (f[0] !== want_f[i]) begin errors++; $display("FAIL bim_flush[%0d] got=%b exp=%b", i, f[0], want_f[i]); end
            checks++; if ({p, f} !== {ep, ef}) begin errors++; $display("FAIL bim_model[%0d] got=%b exp=%b", i, {p, f}, {ep, ef}); end
        end
        set_in(1, 3, 0, 0, 0); settle();
        checks++; if (pred_v[0] !== 1'b1) begin errors++; $display("FAIL bim_after_nt got=%b exp=1", pred_v[0]); end
        tick();
    endtask

    task automatic test_stall_hold();
        int nb0;
        set_in(1, 3, 0, 0, 0); settle(); tick();
        nb0 = nb[0];
        for (int i = 0; i < 3; i++) begin
            set_in(1, 3, 1, 1, 0); settle();
            checks++; if ({pred_v, flush_v} !== 6'b0) begin errors++; $display("FAIL stall_outs[%0d] got=%b exp=000000", i, {pred_v, flush_v}); end
            checks++; if (pb0 !== 16'(nb0)) begin errors++; $display("FAIL stall_perf[%0d] got=%0d exp=%0d", i, pb0, nb0); end
            tick();
        end
        set_in(0, 0, 1, 0, 0); settle();
        checks++; if (flush_v[0] !== 1'b1 || flush_v !== vec_flush()) begin errors++; $display("FAIL stall_release_flush got=%b exp=%b", flush_v, vec_flush()); end
        tick();
        set_in(0, 0, 0, 0, 0); settle();
        checks++; if (pb0 !== 16'(nb0 + 1)) begin errors++; $display("FAIL stall_single_resolve got=%0d exp=%0d", pb0, nb0 + 1); end
        tick();
    endtask

    task automatic test_gshare();
        logic [2:0] p, f, ep, ef;
        reset_pulse();
        branch_pair(7, 1, p, f, ep, ef);
        branch_pair(0, 0, p, f, ep, ef);
        set_in(1, 5, 0, 0, 0); settle();
        checks++; if (pred_v !== 3'b110 || pred_v !== vec_pred()) begin errors++; $display("FAIL gshare_addr5 got=%b exp=110", pred_v); end
        tick();
        set_in(1, 7, 0, 0, 0); settle();
        checks++; if (pred_v[1:0] !== 2'b01) begin errors++; $display("FAIL gshare_addr7 got=%b exp=01", pred_v[1:0]); end
        tick();
    endtask

    task automatic test_same_cycle();
        reset_pulse();
        set_in(1, 4, 0, 0, 0); settle(); tick();
        set_in(1, 4, 1, 0, 1); settle();
        checks++; if (pred_v !== 3'b000) begin errors++; $display("FAIL same_cycle_old got=%b exp=000", pred_v); end
        checks++; if (flush_v !== 3'b111) begin errors++; $display("FAIL same_cycle_flush got=%b exp=111", flush_v); end
        tick();
        set_in(1, 4, 0, 0, 0); settle();
        checks++; if (pred_v !== 3'b001) begin errors++; $display("FAIL same_cycle_new got=%b exp=001", pred_v); end
        tick();
    endtask

    task automatic test_saturation();
        logic [2:0] p, f, ep, ef;
        int a;
        reset_pulse();
        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(0, 31));
            branch_pair(a, taken_of(2, a) == 0, p, f, ep, ef);
            checks++; if (f[2] !== 1'b1) begin errors++; $display("FAIL sat_mispredict[%0d] got=%b exp=1", i, f[2]); end
        end
        set_in(0, 0, 0, 0, 0); settle();
        checks++; if ({pb2, pm2} !== 8'hff) begin errors++; $display("FAIL sat_perf4 got=%h exp=ff", {pb2, pm2}); end
        checks++; if (pb0 !== 16'd20 || {pb0, pm0, pb1, pm1, pb2, pm2} !== exp_perf()) begin errors++; $display("FAIL sat_perf16 got=%0d exp=20", pb0); end
        tick();
        rst_n = 1'b0; set_in(0, 0, 1, 0, 1); settle(); tick();
        rst_n = 1'b1; set_in(0, 0, 0, 0, 0); settle();
        checks++; if ({pb0, pm0, pb1, pm1, pb2, pm2} !== 72'd0) begin errors++; $display("FAIL sat_reset got=%h exp=0", {pb0, pm0, pb1, pm1, pb2, pm2}); end
        tick();
    endtask

    task automatic test_random();
        reset_pulse();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            set_in(1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
                   1'($urandom), $urandom_range(0, 4) == 0, 1'($urandom));
            settle();
            checks++; if (pred_v !== vec_pred()) begin errors++; $display("FAIL rand_pred[%0d] got=%b exp=%b", i, pred_v, vec_pred()); end
            checks++; if (flush_v !== vec_flush()) begin errors++; $display("FAIL rand_flush[%0d] got=%b exp=%b", i, flush_v, vec_flush()); end
            checks++; if ({pb0, pm0, pb1, pm1, pb2, pm2} !== exp_perf()) begin errors++; $display("FAIL rand_perf[%0d] got=%h exp=%h", i, {pb0, pm0, pb1, pm1, pb2, pm2}, exp_perf()); end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        test_reset();
        test_bimodal_training();
        test_stall_hold();
        test_gshare();
        test_same_cycle();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
